dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
// - Sequencing controller for the 2-way set-associative dcache SRAM (16 sets, 256-bit lines, 25-bit tag word).
// - Serves CPU word loads/stores; on a miss, writes back a dirty victim, refills the line from memory, then replays the request.
// - Sits between the CPU data port, dcache_sram, and the off-chip memory port.
// - Tag word: [24] valid, [23] dirty, [22:0] address tag. The SRAM owns LRU and the dirty/valid setting on its write path.
// PARAMETERS
// - ADDR_W   32   CPU/memory byte-address width
// - WORD_W   32   CPU data word width
// - LINE_W   256  cache line width (32 bytes)
// - INDEX_W  4    set index width; index = addr[8:5]
// - TAG_W    23   address tag width; tag = addr[31:9]
// PORTS
// - clk_i        in   1    clock
// - rst_i        in   1    reset, asynchronous, active-high
// - cpu_req_i    in   1    CPU access request; held stable with addr/data/write while stalled
// - cpu_write_i  in   1    1 = store, 0 = load
// - cpu_addr_i   in   32   byte address; [4:2] is the word select
// - cpu_data_i   in   32   store data
// - cpu_data_o   out  32   load data; valid when cpu_req_i & ~cpu_stall_o
// - cpu_stall_o  out  1    CPU must hold its request
// - sram_enable_o out 1    dcache_sram enable
// - sram_write_o out  1    dcache_sram write strobe
// - sram_addr_o  out  4    set index
// - sram_tag_o   out  25   {2'b00, tag}; only [22:0] is used by the SRAM
// - sram_data_o  out  256  line write data
// - sram_tag_i   in   25   hit way's tag, or the victim (LRU) way's tag
// - sram_data_i  in   256  hit line, or the victim line
// - sram_hit_i   in   1    tag match in a valid way
// - mem_req_o    out  1    memory request; held until mem_ack_i
// - mem_write_o  out  1    1 = line writeback, 0 = line read
// - mem_addr_o   out  32   line-aligned address ([4:0] = 0)
// - mem_data_o   out  256  writeback line
// - mem_data_i   in   256  refill line; valid with mem_ack_i
// - mem_ack_i    in   1    one-cycle completion pulse; allowed no earlier than 1 cycle after mem_req_o rises
// BEHAVIOUR
// - Reset (async): state = IDLE; mem_req_o = 0; mem_write_o = 0; all latches cleared; sram_write_o = 0; cpu_stall_o = cpu_req_i.
// - FSM states: IDLE, WBACK, REFILL, UPDATE.
// - IDLE
//   - sram_enable_o = cpu_req_i; the SRAM index and tag come from cpu_addr_i.
//   - Read hit: cpu_data_o = sram_data_i word [addr[4:2]*32 +: 32]; stall = 0; zero-latency, combinational.
//   - Write hit: sram_write_o = 1 with the line merged (selected word replaced by cpu_data_i); stall = 0. The SRAM marks the line dirty.
//   - Miss: stall = 1. Latch index, tag, victim tag and victim line.
//     - Next state is WBACK if victim [24] & [23] are both set; otherwise REFILL.
// - WBACK
//   - mem_req_o = 1, mem_write_o = 1.
//   - mem_addr_o = {victim_tag, index, 5'b0}; mem_data_o = latched victim line.
//   - On mem_ack_i: next state REFILL.
// - REFILL
//   - mem_req_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 5'b0}.
//   - On mem_ack_i: capture mem_data_i; next state UPDATE.
// - UPDATE
//   - Single cycle: sram_enable_o = 1, sram_write_o = 1 with the refill line and latched tag/index.
//   - The SRAM writes the LRU way as valid-clean and flips LRU.
//   - Next state IDLE, where the request replays as a hit. A store replay sets dirty.
// - cpu_stall_o = cpu_req_i & ~(state == IDLE & sram_hit_i).
// - mem_req_o, mem_write_o and mem_addr_o are registered and stable from request until ack. They drop in the cycle after the ack.
// - CPU request dropped mid-miss: the memory transaction and UPDATE still complete, then IDLE. No abort.
// - mem_ack_i outside WBACK/REFILL: ignored.
// - Reset mid-WBACK/REFILL: immediate return to IDLE; mem_req_o falls asynchronously.
// - Load miss to a set whose victim is clean: 0 writebacks. Worst-case miss = WBACK + REFILL + UPDATE + replay.
// STRUCTURE
// - Shared package dcache_pkg:
//   - state enum, TAG_VALID_BIT = 24, TAG_DIRTY_BIT = 23
//   - field helpers: idx(addr), tag(addr), word_sel(addr)
// - Sub-module dcache_word_merge (combinational, 32-bit into 256-bit at word_sel); also used for load word extraction.
// - Controller: FSM + latches only. The SRAM is instantiated at the level above.
// TESTING
// - Cold read miss, addr 0x0000_0204: 1 REFILL at mem_addr 0x200, ack after 3 cycles.
//   - Then UPDATE, then hit; cpu_data_o = word 1 of the line; stall for exactly 6 cycles.
// - Write hit, 0xDEADBEEF at 0x208: sram_write_o for 1 cycle, stall 0, tag dirty afterwards.
//   - Readback of 0x208 returns 0xDEADBEEF.
// - Dirty eviction: fill both ways of set 0 (0x000, 0x200), dirty 0x000, then access 0x400.
//   - Expect WBACK of 0x000 with the modified line, then REFILL of 0x400.
// - Clean victim: same as above without the store.
//   - No WBACK; mem_write_o stays 0 throughout.
// - mem_ack_i after 1 cycle vs after 20 cycles: identical results.
//   - mem_addr_o and mem_data_o are stable during the entire request.
// - rst_i pulsed mid-REFILL: mem_req_o = 0 immediately; state IDLE.
//   - A subsequent access is serviced correctly.

Source files
------------

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dcache_pkg
// Purpose  : Shared geometry constants, FSM state codes and address field
//            helpers for the dcache controller slice.
// Revision : 1.0 - initial release
// ============================================================================
package dcache_pkg;

  // Geometry of the 2-way, 16-set, 32-byte-line data cache
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int LINE_W     = 256;
  localparam int INDEX_W    = 4;
  localparam int TAG_W      = 23;
  localparam int OFFSET_W   = 5;
  localparam int WSEL_W     = 3;
  localparam int SRAM_TAG_W = 25;

  // Status bits inside the SRAM tag word
  localparam int TAG_VALID_BIT = 24;
  localparam int TAG_DIRTY_BIT = 23;

  // Controller states
  localparam int STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WBACK  = 2'd1;
  localparam state_t ST_REFILL = 2'd2;
  localparam state_t ST_UPDATE = 2'd3;

  // Set index: addr[8:5]
  function automatic logic [INDEX_W-1:0] idx(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W +: INDEX_W];
  endfunction

  // Address tag: addr[31:9]
  function automatic logic [TAG_W-1:0] tag(input logic [ADDR_W-1:0] addr);
    return addr[OFFSET_W+INDEX_W +: TAG_W];
  endfunction

  // Word select within the line: addr[4:2]
  function automatic logic [WSEL_W-1:0] word_sel(input logic [ADDR_W-1:0] addr);
    return addr[2 +: WSEL_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_word_merge.sv
`default_nettype none
// ============================================================================
// Module   : dcache_word_merge
// Purpose  : Combinational word lane logic. Replaces one word of a line with
//            store data and extracts the selected word for loads.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_word_merge #(
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SEL_W  = 3
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic [LINE_W-1:0] line_o,
  output logic [WORD_W-1:0] word_o
);

  localparam int c_words = LINE_W / WORD_W;

  // Each lane takes the store word when selected, otherwise keeps the line
  genvar g;
  generate
    for (g = 0; g < c_words; g++) begin : g_lane
      assign line_o[g*WORD_W +: WORD_W] =
        (sel_i == SEL_W'(g)) ? word_i : line_i[g*WORD_W +: WORD_W];
    end
  endgenerate

  // Load extraction of the selected word
  assign word_o = line_i[sel_i*WORD_W +: WORD_W];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Purpose  : Sequencing controller for the 2-way set-associative dcache SRAM.
//            Serves CPU hits combinationally; on a miss writes back a dirty
//            victim, refills the line from memory and replays the request.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  // CPU data port
  input  logic                  cpu_req_i,
  input  logic                  cpu_write_i,
  input  logic [ADDR_W-1:0]     cpu_addr_i,
  input  logic [WORD_W-1:0]     cpu_data_i,
  output logic [WORD_W-1:0]     cpu_data_o,
  output logic                  cpu_stall_o,
  // dcache_sram port
  output logic                  sram_enable_o,
  output logic                  sram_write_o,
  output logic [INDEX_W-1:0]    sram_addr_o,
  output logic [SRAM_TAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0]     sram_data_o,
  input  logic [SRAM_TAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0]     sram_data_i,
  input  logic                  sram_hit_i,
  // Off-chip memory port
  output logic                  mem_req_o,
  output logic                  mem_write_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [LINE_W-1:0]     mem_data_o,
  input  logic [LINE_W-1:0]     mem_data_i,
  input  logic                  mem_ack_i
);

  // --------------------------------------------------------------------------
  // State and miss latches
  // --------------------------------------------------------------------------
  state_t              r_state;
  logic [INDEX_W-1:0]  r_index;
  logic [TAG_W-1:0]    r_tag;
  logic [LINE_W-1:0]   r_victim_line;
  logic [LINE_W-1:0]   r_refill_line;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  logic [INDEX_W-1:0]  w_cpu_index;
  logic [TAG_W-1:0]    w_cpu_tag;
  logic [WSEL_W-1:0]   w_word_sel;
  logic                w_idle;
  logic                w_update;
  logic                w_miss;
  logic                w_victim_dirty;
  logic [LINE_W-1:0]   w_merged_line;
  logic [WORD_W-1:0]   w_load_word;

  assign w_cpu_index    = idx(cpu_addr_i);
  assign w_cpu_tag      = tag(cpu_addr_i);
  assign w_word_sel     = word_sel(cpu_addr_i);
  assign w_idle         = (r_state == ST_IDLE);
  assign w_update       = (r_state == ST_UPDATE);
  assign w_miss         = w_idle & cpu_req_i & ~sram_hit_i;
  // On a miss the SRAM presents the LRU way, which is the victim
  assign w_victim_dirty = sram_tag_i[TAG_VALID_BIT] & sram_tag_i[TAG_DIRTY_BIT];

  dcache_word_merge #(
    .WORD_W (WORD_W),
    .LINE_W (LINE_W),
    .SEL_W  (WSEL_W)
  ) u_word_merge (
    .line_i (sram_data_i),
    .word_i (cpu_data_i),
    .sel_i  (w_word_sel),
    .line_o (w_merged_line),
    .word_o (w_load_word)
  );

  // --------------------------------------------------------------------------
  // SRAM and CPU side outputs. In IDLE the SRAM is addressed straight from the
  // CPU so hits complete with zero latency; in UPDATE the latched miss address
  // and refill line are written. Reset masks the write strobe and the hit path.
  // --------------------------------------------------------------------------
  assign sram_enable_o = w_idle ? cpu_req_i : w_update;
  assign sram_write_o  = ~rst_i & ((w_idle & cpu_req_i & cpu_write_i & sram_hit_i) | w_update);
  assign sram_addr_o   = w_idle ? w_cpu_index : r_index;
  assign sram_tag_o    = {2'b00, (w_idle ? w_cpu_tag : r_tag)};
  assign sram_data_o   = w_update ? r_refill_line : w_merged_line;
  assign cpu_data_o    = w_load_word;
  assign cpu_stall_o   = cpu_req_i & ~(w_idle & sram_hit_i & ~rst_i);
  assign mem_data_o    = r_victim_line;

  // --------------------------------------------------------------------------
  // Miss sequencer: FSM, miss latches and registered memory request.
  // The writeback address is loaded into mem_addr_o directly from the victim
  // tag, so no separate victim-tag register is kept.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_tag         <= '0;
      r_victim_line <= '0;
      r_refill_line <= '0;
      mem_req_o     <= 1'b0;
      mem_write_o   <= 1'b0;
      mem_addr_o    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_miss) begin
            r_index       <= w_cpu_index;
            r_tag         <= w_cpu_tag;
            r_victim_line <= sram_data_i;
            mem_req_o     <= 1'b1;
            if (w_victim_dirty) begin
              r_state     <= ST_WBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {sram_tag_i[TAG_W-1:0], w_cpu_index, {OFFSET_W{1'b0}}};
            end else begin
              r_state     <= ST_REFILL;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {w_cpu_tag, w_cpu_index, {OFFSET_W{1'b0}}};
            end
          end
        end
        ST_WBACK: begin
          // Request stays up; it turns into the refill read after the ack
          if (mem_ack_i) begin
            r_state     <= ST_REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {r_tag, r_index, {OFFSET_W{1'b0}}};
          end
        end
        ST_REFILL: begin
          if (mem_ack_i) begin
            r_state       <= ST_UPDATE;
            r_refill_line <= mem_data_i;
            mem_req_o     <= 1'b0;
          end
        end
        ST_UPDATE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          mem_req_o   <= 1'b0;
          mem_write_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Purpose  : Self-checking bench for dcache_ctrl with behavioural SRAM and
//            memory models and a flat word-level golden memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o;
  logic         sram_enable_o, sram_write_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o, sram_tag_i;
  logic [255:0] sram_data_o, sram_data_i;
  logic         sram_hit_i;
  logic         mem_req_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic         mem_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Golden memory (word granular) and backing memory contents
  // --------------------------------------------------------------------------
  logic [31:0] gold [int unsigned];
  logic [31:0] mem_w [int unsigned];

  function automatic logic [31:0] dflt(input int unsigned wa);
    return (wa * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] gold_rd(input int unsigned wa);
    return gold.exists(wa) ? gold[wa] : dflt(wa);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    int unsigned wa;
    for (int k = 0; k < 8; k++) begin
      wa = (la >> 2) + k;
      l[k*32 +: 32] = mem_w.exists(wa) ? mem_w[wa] : dflt(wa);
    end
    return l;
  endfunction

  function automatic logic [255:0] gold_line(input logic [31:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = gold_rd((la >> 2) + k);
    return l;
  endfunction

  // --------------------------------------------------------------------------
  // Behavioural dcache_sram: 2 ways, LRU flipped only on line allocation
  // --------------------------------------------------------------------------
  logic [22:0]  s_tag  [16][2];
  logic [255:0] s_data [16][2];
  bit           s_v    [16][2];
  bit           s_d    [16][2];
  bit           s_lru  [16];
  int           rd_way;
  logic         rd_hit;

  // Read side: hit way, otherwise the LRU victim
  always_comb begin
    rd_hit = 1'b0;
    rd_way = int'(s_lru[sram_addr_o]);
    for (int w = 0; w < 2; w++)
      if (s_v[sram_addr_o][w] && s_tag[sram_addr_o][w] == sram_tag_o[22:0]) begin
        rd_hit = 1'b1;
        rd_way = w;
      end
    sram_hit_i  = rd_hit;
    sram_tag_i  = {s_v[sram_addr_o][rd_way], s_d[sram_addr_o][rd_way], s_tag[sram_addr_o][rd_way]};
    sram_data_i = s_data[sram_addr_o][rd_way];
  end

  // --------------------------------------------------------------------------
  // Environment process: SRAM writes, cache flush requests, memory responder
  // --------------------------------------------------------------------------
  int           ack_delay = 3;
  int           clear_cnt = 0, clear_seen = 0;
  int           spur_cnt = 0, spur_seen = 0;
  int           stab_err = 0;
  int           mem_write_cycles = 0;
  int           n_txn = 0;
  logic [31:0]  log_addr  [int];
  bit           log_write [int];
  logic [255:0] log_data  [int];

  always @(posedge clk_i) begin : env_proc
    logic         we;
    logic [3:0]   wa;
    logic [22:0]  wt;
    logic [255:0] wd;
    int           ww;
    bit           wh;
    bit           busy;
    int           cnt;
    logic [31:0]  t_a;
    bit           t_w;
    logic [255:0] t_d;
    logic [31:0]  la;
    we = sram_enable_o && sram_write_o && !rst_i;
    wa = sram_addr_o;
    wt = sram_tag_o[22:0];
    wd = sram_data_o;
    #1;
    if (we) begin
      wh = 0;
      ww = int'(s_lru[wa]);
      for (int w = 0; w < 2; w++)
        if (s_v[wa][w] && s_tag[wa][w] == wt) begin wh = 1; ww = w; end
      if (wh) begin
        s_data[wa][ww] = wd;
        s_d[wa][ww]    = 1;
      end else begin
        s_tag[wa][ww]  = wt;
        s_data[wa][ww] = wd;
        s_v[wa][ww]    = 1;
        s_d[wa][ww]    = 0;
        s_lru[wa]      = !s_lru[wa];
      end
    end
    if (clear_seen != clear_cnt) begin
      clear_seen = clear_cnt;
      for (int s = 0; s < 16; s++) begin
        for (int w = 0; w < 2; w++) begin
          if (s_v[s][w] && s_d[s][w]) begin
            la = {s_tag[s][w], 4'(s), 5'b0};
            for (int k = 0; k < 8; k++) mem_w[(la >> 2) + k] = s_data[s][w][k*32 +: 32];
          end
          s_v[s][w] = 0;
          s_d[s][w] = 0;
        end
        s_lru[s] = 0;
      end
    end
    if (rst_i) begin
      mem_ack_i = 1'b0;
      busy      = 0;
    end else begin
      if (mem_ack_i) begin
        if (busy && t_w)
          for (int k = 0; k < 8; k++) mem_w[(t_a >> 2) + k] = t_d[k*32 +: 32];
        mem_ack_i = 1'b0;
        busy      = 0;
      end
      if (mem_req_o && !busy) begin
        busy = 1;
        cnt  = 0;
        t_a  = mem_addr_o;
        t_w  = mem_write_o;
        t_d  = mem_data_o;
        log_addr[n_txn]  = t_a;
        log_write[n_txn] = t_w;
        log_data[n_txn]  = t_d;
        n_txn++;
      end else if (busy) begin
        cnt++;
        if (!mem_req_o || mem_addr_o !== t_a || mem_write_o !== t_w ||
            (t_w && mem_data_o !== t_d))
          stab_err++;
        if (cnt == ack_delay) begin
          mem_ack_i = 1'b1;
          if (!t_w) mem_data_i = mem_line(t_a);
        end
      end
      if (mem_write_o) mem_write_cycles++;
      if (spur_seen != spur_cnt) begin
        spur_seen = spur_cnt;
        if (!busy) mem_ack_i = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // CPU helpers
  // --------------------------------------------------------------------------
  task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output int stalls,
                            output int swrites, output bit timeout);
    bit done = 0;
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    stalls = 0; swrites = 0; rdata = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (sram_write_o) swrites++;
      if (!cpu_stall_o) begin
        rdata = cpu_data_o;
        done  = 1;
      end else begin
        stalls++;
        @(negedge clk_i);
      end
    end
    timeout = !done;
    @(posedge clk_i);
  endtask

  task automatic cpu_idle();
    @(negedge clk_i);
    cpu_req_i = 1'b0;
  endtask

  task automatic clear_cache();
    cpu_idle();
    clear_cnt++;
    repeat (2) @(negedge clk_i);
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b1;
    #1;
    n_checks++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b expected 1", cpu_stall_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b expected 0", mem_req_o); end
    n_checks++; if (mem_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_write: got %b expected 0", mem_write_o); end
    n_checks++; if (sram_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_sram_write: got %b expected 0", sram_write_o); end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_cold_read_miss();
    logic [31:0] rd; int st, sw, n0; bit to;
    ack_delay = 3;
    n0 = n_txn;
    cpu_access(0, 32'h0000_0204, 32'h0, rd, st, sw, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL cold_timeout: got timeout expected completion"); end
    n_checks++; if (st !== 6) begin n_fail++; $display("FAIL cold_stall: got %0d expected 6", st); end
    n_checks++; if (rd !== gold_rd(32'h204 >> 2)) begin n_fail++; $display("FAIL cold_data: got %h expected %h", rd, gold_rd(32'h204 >> 2)); end
    n_checks++; if (n_txn - n0 !== 1) begin n_fail++; $display("FAIL cold_txn_count: got %0d expected 1", n_txn - n0); end
    n_checks++; if (log_addr[n0] !== 32'h200 || log_write[n0] !== 1'b0) begin n_fail++; $display("FAIL cold_txn: got addr %h write %b expected 200 read", log_addr[n0], log_write[n0]); end
    n_checks++; if (sw !== 1) begin n_fail++; $display("FAIL cold_sram_writes: got %0d expected 1", sw); end
    #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL cold_req_drop: got %b expected 0", mem_req_o); end
    cpu_idle();
  endtask

  task automatic test_write_hit();
    logic [31:0] rd; int st, sw, n0; bit to, dirty;
    n0 = n_txn;
    cpu_access(1, 32'h0000_0208, 32'hDEAD_BEEF, rd, st, sw, to);
    gold[32'h208 >> 2] = 32'hDEAD_BEEF;
    n_checks++; if (to || st !== 0) begin n_fail++; $display("FAIL whit_stall: got %0d expected 0", st); end
    n_checks++; if (sw !== 1) begin n_fail++; $display("FAIL whit_sram_writes: got %0d expected 1", sw); end
    n_checks++; if (n_txn !== n0) begin n_fail++; $display("FAIL whit_no_mem: got %0d txns expected 0", n_txn - n0); end
    cpu_idle();
    dirty = 0;
    for (int w = 0; w < 2; w++)
      if (s_v[0][w] && s_tag[0][w] == 23'd1 && s_d[0][w]) dirty = 1;
    n_checks++; if (dirty !== 1'b1) begin n_fail++; $display("FAIL whit_dirty: got %b expected 1", dirty); end
    cpu_access(0, 32'h0000_0208, 32'h0, rd, st, sw, to);
    n_checks++; if (rd !== 32'hDEAD_BEEF || st !== 0) begin n_fail++; $display("FAIL whit_readback: got %h stall %0d expected deadbeef stall 0", rd, st); end
    cpu_idle();
  endtask

  task automatic test_dirty_evict();
    logic [31:0] rd, val; int st, sw, n0; bit to;
    clear_cache();
    ack_delay = 3;
    val = $urandom;
    cpu_access(0, 32'h000, 0, rd, st, sw, to);
    cpu_access(0, 32'h200, 0, rd, st, sw, to);
    cpu_access(1, 32'h004, val, rd, st, sw, to);
    gold[1] = val;
    n0 = n_txn;
    cpu_access(0, 32'h400, 0, rd, st, sw, to);
    n_checks++; if (n_txn - n0 !== 2) begin n_fail++; $display("FAIL evict_txn_count: got %0d expected 2", n_txn - n0); end
    n_checks++; if (log_write[n0] !== 1'b1 || log_addr[n0] !== 32'h0) begin n_fail++; $display("FAIL evict_wback: got addr %h write %b expected 0 write", log_addr[n0], log_write[n0]); end
    n_checks++; if (log_data[n0] !== gold_line(32'h0)) begin n_fail++; $display("FAIL evict_wback_data: got %h expected %h", log_data[n0], gold_line(32'h0)); end
    n_checks++; if (log_write[n0+1] !== 1'b0 || log_addr[n0+1] !== 32'h400) begin n_fail++; $display("FAIL evict_refill: got addr %h write %b expected 400 read", log_addr[n0+1], log_write[n0+1]); end
    n_checks++; if (to || st !== 10) begin n_fail++; $display("FAIL evict_stall: got %0d expected 10", st); end
    n_checks++; if (rd !== gold_rd(32'h400 >> 2)) begin n_fail++; $display("FAIL evict_data: got %h expected %h", rd, gold_rd(32'h400 >> 2)); end
    cpu_idle();
  endtask

  task automatic test_clean_victim();
    logic [31:0] rd; int st, sw, n0, mw0; bit to;
    clear_cache();
    ack_delay = 3;
    cpu_access(0, 32'h000, 0, rd, st, sw, to);
    cpu_access(0, 32'h200, 0, rd, st, sw, to);
    n0 = n_txn; mw0 = mem_write_cycles;
    cpu_access(0, 32'h404, 0, rd, st, sw, to);
    n_checks++; if (n_txn - n0 !== 1 || log_write[n0] !== 1'b0 || log_addr[n0] !== 32'h400) begin n_fail++; $display("FAIL clean_txn: got %0d txns first addr %h expected one read of 400", n_txn - n0, log_addr[n0]); end
    n_checks++; if (mem_write_cycles !== mw0) begin n_fail++; $display("FAIL clean_mem_write: got %0d write cycles expected 0", mem_write_cycles - mw0); end
    n_checks++; if (to || st !== 6 || rd !== gold_rd(32'h404 >> 2)) begin n_fail++; $display("FAIL clean_result: got %h stall %0d expected %h stall 6", rd, st, gold_rd(32'h404 >> 2)); end
    cpu_idle();
  endtask

  task automatic test_ack_latency();
    int dl [2] = '{1, 20};
    logic [31:0] rd, val; int st, sw, n0, se0; bit to;
    for (int i = 0; i < 2; i++) begin
      clear_cache();
      ack_delay = dl[i];
      se0 = stab_err;
      val = $urandom;
      cpu_access(1, 32'h0A4, val, rd, st, sw, to);
      gold[32'h0A4 >> 2] = val;
      n_checks++; if (to || st !== dl[i] + 3 || sw !== 2) begin n_fail++; $display("FAIL lat%0d_store_miss: got stall %0d writes %0d expected %0d 2", dl[i], st, sw, dl[i] + 3); end
      cpu_access(0, 32'h2A0, 0, rd, st, sw, to);
      n0 = n_txn;
      cpu_access(0, 32'h4A4, 0, rd, st, sw, to);
      n_checks++; if (to || st !== 2 * dl[i] + 4) begin n_fail++; $display("FAIL lat%0d_evict_stall: got %0d expected %0d", dl[i], st, 2 * dl[i] + 4); end
      n_checks++; if (log_addr[n0] !== 32'h0A0 || log_data[n0][63:32] !== val) begin n_fail++; $display("FAIL lat%0d_wback: got addr %h word %h expected 0a0 %h", dl[i], log_addr[n0], log_data[n0][63:32], val); end
      n_checks++; if (rd !== gold_rd(32'h4A4 >> 2)) begin n_fail++; $display("FAIL lat%0d_data: got %h expected %h", dl[i], rd, gold_rd(32'h4A4 >> 2)); end
      n_checks++; if (stab_err !== se0) begin n_fail++; $display("FAIL lat%0d_stable: got %0d unstable cycles expected 0", dl[i], stab_err - se0); end
      cpu_idle();
    end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] rd; int st, sw, n0; bit to, seen;
    clear_cache();
    ack_delay = 20;
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h648;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (mem_req_o && !mem_write_o) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL rst_refill_seen: got no refill expected refill"); end
    repeat (3) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_req: got %b expected 0", mem_req_o); end
    n_checks++; if (cpu_stall_o !== 1'b1) begin n_fail++; $display("FAIL rst_mid_stall: got %b expected 1", cpu_stall_o); end
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_delay = 3;
    n0 = n_txn;
    cpu_access(0, 32'h648, 0, rd, st, sw, to);
    n_checks++; if (to || st !== 6 || rd !== gold_rd(32'h648 >> 2)) begin n_fail++; $display("FAIL rst_after: got %h stall %0d expected %h stall 6", rd, st, gold_rd(32'h648 >> 2)); end
    n_checks++; if (log_addr[n0] !== 32'h640) begin n_fail++; $display("FAIL rst_after_addr: got %h expected 640", log_addr[n0]); end
    cpu_idle();
  endtask

  task automatic test_spurious_ack();
    logic [31:0] rd; int st, sw, n0; bit to;
    n0 = n_txn;
    spur_cnt++;
    repeat (3) @(negedge clk_i);
    cpu_access(0, 32'h64C, 0, rd, st, sw, to);
    n_checks++; if (to || st !== 0 || rd !== gold_rd(32'h64C >> 2) || n_txn !== n0) begin n_fail++; $display("FAIL spurious_ack: got %h stall %0d txns %0d expected %h 0 0", rd, st, n_txn - n0, gold_rd(32'h64C >> 2)); end
    cpu_idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, val; int st, sw, n0; bit to, wr;
    clear_cache();
    for (int i = 0; i < 200; i++) begin
      ack_delay = $urandom_range(1, 4);
      addr = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      wr   = ($urandom_range(0, 2) == 0);
      val  = $urandom;
      n0   = n_txn;
      cpu_access(wr, addr, val, rd, st, sw, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand_timeout: access %0d addr %h", i, addr); end
      if (!wr) begin
        n_checks++; if (rd !== gold_rd(addr >> 2)) begin n_fail++; $display("FAIL rand_load: addr %h got %h expected %h", addr, rd, gold_rd(addr >> 2)); end
      end
      for (int t = n0; t < n_txn; t++) begin
        if (log_write[t]) begin
          n_checks++; if (log_data[t] !== gold_line(log_addr[t])) begin n_fail++; $display("FAIL rand_wback: addr %h got %h expected %h", log_addr[t], log_data[t], gold_line(log_addr[t])); end
        end else begin
          n_checks++; if (log_addr[t] !== (addr & 32'hFFFF_FFE0)) begin n_fail++; $display("FAIL rand_refill_addr: got %h expected %h", log_addr[t], addr & 32'hFFFF_FFE0); end
        end
      end
      if (wr) gold[addr >> 2] = val;
      if ($urandom_range(0, 3) == 0) cpu_idle();
    end
    cpu_idle();
    n_checks++; if (stab_err !== 0) begin n_fail++; $display("FAIL mem_stability: got %0d unstable cycles expected 0", stab_err); end
  endtask

  initial begin
    rst_i = 1'b1;
    cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    repeat (3) @(posedge clk_i);
    test_reset();
    test_cold_read_miss();
    test_write_hit();
    test_dirty_evict();
    test_clean_victim();
    test_ack_latency();
    test_reset_mid_refill();
    test_spurious_ack();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
